// File: rtl/ifetch_unit_pkg.sv
// Shared types for the instruction fetch unit: addresses, instruction words,
// the delivered fetch packet and the memory request format.
package ifetch_unit_pkg;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;

   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [INSTR_W-1:0] instr_t;

   typedef struct packed {
      instr_t raw;
      addr_t  pc;
   } fetch_pkt_t;

   typedef struct packed {
      addr_t       a;
      logic        we;
      logic [3:0]  be;
      logic [31:0] d;
   } mem_req_t;

   localparam int FETCH_W  = $bits(fetch_pkt_t);
   localparam int MEMREQ_W = $bits(mem_req_t);

   // Instruction fetches are always whole-word reads; be/d carry no meaning.
   function automatic mem_req_t make_read(input addr_t a);
      mem_req_t r;
      r.a  = a;
      r.we = 1'b0;
      r.be = 4'hf;
      r.d  = '0;
      return r;
   endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Generic valid/ready channel. The producer side uses the master modport,
// the consumer side uses the slave modport.
interface ifetch_unit_if #(
   parameter int W = 32
) ();

   logic         valid;
   logic         ready;
   logic [W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/ifetch_addr_fifo.sv
// Address FIFO holding the PCs of live (not killed) memory requests in issue
// order. The head is visible combinationally so a response can be tagged with
// its address in the same cycle it arrives.
module ifetch_addr_fifo
   import ifetch_unit_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  addr_t            push_data,
   input  logic             pop,
   output addr_t            head,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   addr_t            mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; clear empties the FIFO without
   // touching the stored addresses.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Address storage; contents are only meaningful below count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues fetch addresses to memory, pairs in-order
// memory responses with their PCs and delivers them with zero added latency.
// A flush turns every live request into a killed one whose response is
// silently dropped when it eventually returns.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter int MAX_INFLIGHT = 2
) (
   input  logic          clk,
   input  logic          rst,
   ifetch_unit_if.slave  pc,
   ifetch_unit_if.master fetched,
   input  logic          flush,
   ifetch_unit_if.master mem_req,
   ifetch_unit_if.slave  mem_resp
);

   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

   logic [CNT_W-1:0] live;
   logic [CNT_W-1:0] kill_cnt;
   logic [CNT_W:0]   total;
   logic [CNT_W:0]   owed_after_flush;
   logic             room;
   logic             run;
   logic             fwd;
   logic             issue;
   logic             deliver;
   logic             drop;
   logic             flush_hit;
   addr_t            head;
   fetch_pkt_t       pkt;

   assign total = {1'b0, live} + {1'b0, kill_cnt};
   // A full unit never issues, even if a delivery frees a slot this cycle.
   assign room  = total < (CNT_W + 1)'(MAX_INFLIGHT);
   assign run   = !rst && !flush;
   assign fwd   = run && (kill_cnt == '0);

   // Issue side.
   assign mem_req.valid = run && pc.valid && room;
   assign mem_req.data  = make_read(pc.data);
   assign pc.ready      = run && mem_req.ready && room;
   assign issue         = pc.valid && pc.ready;

   // Delivery side: forward while nothing killed is still owed; otherwise
   // (or during flush) swallow responses unconditionally.
   assign pkt.raw       = mem_resp.data;
   assign pkt.pc        = head;
   assign fetched.data  = pkt;
   assign fetched.valid = fwd && mem_resp.valid && (live != '0);
   assign mem_resp.ready = !rst && (flush || (kill_cnt != '0) || fetched.ready);
   assign deliver       = fetched.valid && fetched.ready;
   assign drop          = run && (kill_cnt != '0) && mem_resp.valid;

   // On flush every outstanding request becomes owed, minus the one whose
   // response is being consumed in the flush cycle itself.
   assign flush_hit        = mem_resp.valid && (total != '0);
   assign owed_after_flush = total - (CNT_W + 1)'(flush_hit);

   ifetch_addr_fifo #(
      .DEPTH (MAX_INFLIGHT)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .push      (issue),
      .push_data (pc.data),
      .pop       (deliver),
      .head      (head),
      .count     (live)
   );

   // Count of responses still to be discarded for killed requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         kill_cnt <= '0;
      end else if (flush) begin
         kill_cnt <= owed_after_flush[CNT_W-1:0];
      end else if (drop) begin
         kill_cnt <= kill_cnt - 1'b1;
      end
   end

`ifndef SYNTHESIS
   // Protocol checks: memory must not answer a request never issued, and
   // the in-flight budget must hold.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(mem_resp.valid && (live == '0) && (kill_cnt == '0)))
            else $error("ifetch_unit: mem_resp with no request in flight");
         assert (total <= (CNT_W + 1)'(MAX_INFLIGHT))
            else $error("ifetch_unit: in-flight budget exceeded");
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, back-to-back issue, backpressure,
// flush with and without a coincident response, and reset mid-flight.
module tb_ifetch_unit;
   import ifetch_unit_pkg::*;

   logic clk;
   logic rst;
   logic flush;
   logic flush3;
   int   checks   = 0;
   int   failures = 0;

   ifetch_unit_if #(.W(ADDR_W))   pc_if ();
   ifetch_unit_if #(.W(FETCH_W))  fet_if ();
   ifetch_unit_if #(.W(MEMREQ_W)) mreq_if ();
   ifetch_unit_if #(.W(INSTR_W))  mresp_if ();

   ifetch_unit_if #(.W(ADDR_W))   pc3_if ();
   ifetch_unit_if #(.W(FETCH_W))  fet3_if ();
   ifetch_unit_if #(.W(MEMREQ_W)) mreq3_if ();
   ifetch_unit_if #(.W(INSTR_W))  mresp3_if ();

   ifetch_unit #(.MAX_INFLIGHT(2)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .pc       (pc_if),
      .fetched  (fet_if),
      .flush    (flush),
      .mem_req  (mreq_if),
      .mem_resp (mresp_if)
   );

   ifetch_unit #(.MAX_INFLIGHT(3)) u_dut3 (
      .clk      (clk),
      .rst      (rst),
      .pc       (pc3_if),
      .fetched  (fet3_if),
      .flush    (flush3),
      .mem_req  (mreq3_if),
      .mem_resp (mresp3_if)
   );

   fetch_pkt_t fpkt, fpkt3;
   mem_req_t   mreq, mreq3;
   assign fpkt  = fet_if.data;
   assign fpkt3 = fet3_if.data;
   assign mreq  = mreq_if.data;
   assign mreq3 = mreq3_if.data;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset with busy-looking inputs: every handshake output must stay low.
      rst = 1'b1; flush = 1'b0; flush3 = 1'b0;
      pc_if.valid = 1'b1; pc_if.data = 32'h100;
      fet_if.ready = 1'b1; mreq_if.ready = 1'b1;
      mresp_if.valid = 1'b1; mresp_if.data = 32'h0;
      pc3_if.valid = 1'b0; pc3_if.data = 32'h0;
      fet3_if.ready = 1'b1; mreq3_if.ready = 1'b1;
      mresp3_if.valid = 1'b0; mresp3_if.data = 32'h0;
      #1;
      chk("rst_mreq_valid", mreq_if.valid, 0);
      chk("rst_pc_ready", pc_if.ready, 0);
      chk("rst_fetched_valid", fet_if.valid, 0);
      chk("rst_mresp_ready", mresp_if.ready, 0);
      step(); step();
      rst = 1'b0; pc_if.valid = 1'b0; mresp_if.valid = 1'b0;
      #1;
      chk("rst_live", u_dut.live, 0);
      chk("rst_kill", u_dut.kill_cnt, 0);
      chk("idle_pc_ready", pc_if.ready, 1);

      // Back-to-back issue, full unit, then in-order delivery.
      pc_if.valid = 1'b1; pc_if.data = 32'h100;
      #1;
      chk("b2b_mreq_valid", mreq_if.valid, 1);
      chk("b2b_mreq_a", mreq.a, 32'h100);
      chk("b2b_mreq_we", mreq.we, 0);
      chk("b2b_pc_ready0", pc_if.ready, 1);
      chk("b2b_no_fetch", fet_if.valid, 0);
      step();
      pc_if.data = 32'h104;
      #1;
      chk("b2b_pc_ready1", pc_if.ready, 1);
      chk("b2b_live1", u_dut.live, 1);
      step();
      pc_if.data = 32'h108; mresp_if.valid = 1'b1; mresp_if.data = 32'hA000_0100;
      #1;
      chk("b2b_full_pc_ready", pc_if.ready, 0);
      chk("b2b_full_mreq_valid", mreq_if.valid, 0);
      chk("b2b_f0_valid", fet_if.valid, 1);
      chk("b2b_f0_pc", fpkt.pc, 32'h100);
      chk("b2b_f0_raw", fpkt.raw, 32'hA000_0100);
      chk("b2b_f0_mresp_ready", mresp_if.ready, 1);
      step();
      mresp_if.data = 32'hA000_0104;
      #1;
      chk("b2b_pc_ready2", pc_if.ready, 1);
      chk("b2b_f1_valid", fet_if.valid, 1);
      chk("b2b_f1_pc", fpkt.pc, 32'h104);
      step();
      pc_if.valid = 1'b0; mresp_if.data = 32'hA000_0108;
      #1;
      chk("b2b_f2_valid", fet_if.valid, 1);
      chk("b2b_f2_pc", fpkt.pc, 32'h108);
      chk("b2b_f2_raw", fpkt.raw, 32'hA000_0108);
      step();
      mresp_if.valid = 1'b0;
      #1;
      chk("b2b_live_end", u_dut.live, 0);

      // Backpressure on fetched with two live requests.
      pc_if.valid = 1'b1; pc_if.data = 32'h300;
      #1; step();
      pc_if.data = 32'h304;
      #1; step();
      pc_if.data = 32'h308; fet_if.ready = 1'b0;
      mresp_if.valid = 1'b1; mresp_if.data = 32'hB000_0300;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_pc_ready", pc_if.ready, 0);
         chk("bp_mreq_valid", mreq_if.valid, 0);
         chk("bp_fetched_valid", fet_if.valid, 1);
         chk("bp_mresp_ready", mresp_if.ready, 0);
         chk("bp_live", u_dut.live, 2);
         step();
      end
      pc_if.valid = 1'b0; fet_if.ready = 1'b1;
      #1;
      chk("bp_f0_valid", fet_if.valid, 1);
      chk("bp_f0_pc", fpkt.pc, 32'h300);
      chk("bp_f0_raw", fpkt.raw, 32'hB000_0300);
      step();
      mresp_if.data = 32'hB000_0304;
      #1;
      chk("bp_f1_valid", fet_if.valid, 1);
      chk("bp_f1_pc", fpkt.pc, 32'h304);
      step();
      mresp_if.valid = 1'b0;
      #1;
      chk("bp_live_end", u_dut.live, 0);

      // Flush with two live, then a new fetch behind the killed responses.
      pc_if.valid = 1'b1; pc_if.data = 32'h200;
      #1; step();
      pc_if.data = 32'h204;
      #1; step();
      flush = 1'b1; pc_if.data = 32'h400;
      #1;
      chk("fl_pc_ready", pc_if.ready, 0);
      chk("fl_mreq_valid", mreq_if.valid, 0);
      chk("fl_fetched_valid", fet_if.valid, 0);
      chk("fl_mresp_ready", mresp_if.ready, 1);
      step();
      flush = 1'b0; mresp_if.valid = 1'b1; mresp_if.data = 32'hC000_0200;
      #1;
      chk("fl_kill2", u_dut.kill_cnt, 2);
      chk("fl_live0", u_dut.live, 0);
      chk("fl_drop0_valid", fet_if.valid, 0);
      chk("fl_drop0_ready", mresp_if.ready, 1);
      chk("fl_full_pc_ready", pc_if.ready, 0);
      step();
      mresp_if.data = 32'hC000_0204;
      #1;
      chk("fl_kill1", u_dut.kill_cnt, 1);
      chk("fl_drop1_valid", fet_if.valid, 0);
      chk("fl_new_pc_ready", pc_if.ready, 1);
      chk("fl_new_mreq_a", mreq.a, 32'h400);
      step();
      pc_if.valid = 1'b0; mresp_if.data = 32'hC000_0400;
      #1;
      chk("fl_kill0", u_dut.kill_cnt, 0);
      chk("fl_new_valid", fet_if.valid, 1);
      chk("fl_new_pc", fpkt.pc, 32'h400);
      chk("fl_new_raw", fpkt.raw, 32'hC000_0400);
      step();
      mresp_if.valid = 1'b0;
      #1;
      chk("fl_live_end", u_dut.live, 0);

      // Flush coinciding with a response.
      pc_if.valid = 1'b1; pc_if.data = 32'h500;
      #1; step();
      pc_if.data = 32'h504;
      #1; step();
      pc_if.valid = 1'b0; flush = 1'b1;
      mresp_if.valid = 1'b1; mresp_if.data = 32'hD000_0500;
      #1;
      chk("flc_fetched_valid", fet_if.valid, 0);
      chk("flc_mresp_ready", mresp_if.ready, 1);
      step();
      flush = 1'b0; mresp_if.data = 32'hD000_0504;
      #1;
      chk("flc_kill1", u_dut.kill_cnt, 1);
      chk("flc_live0", u_dut.live, 0);
      chk("flc_drop_valid", fet_if.valid, 0);
      step();
      mresp_if.valid = 1'b0;
      #1;
      chk("flc_kill0", u_dut.kill_cnt, 0);

      // Reset mid-flight on the MAX_INFLIGHT=3 instance: 2 live, 1 killed.
      pc3_if.valid = 1'b1; pc3_if.data = 32'hA00;
      #1; step();
      pc3_if.valid = 1'b0; flush3 = 1'b1;
      #1; step();
      flush3 = 1'b0; pc3_if.valid = 1'b1; pc3_if.data = 32'hA10;
      #1;
      chk("rm_pc_ready0", pc3_if.ready, 1);
      step();
      pc3_if.data = 32'hA14;
      #1;
      chk("rm_pc_ready1", pc3_if.ready, 1);
      step();
      rst = 1'b1; pc3_if.data = 32'hA18;
      mresp3_if.valid = 1'b1; mresp3_if.data = 32'hEEEE_EEEE;
      #1;
      chk("rm_pre_live", u_dut3.live, 2);
      chk("rm_pre_kill", u_dut3.kill_cnt, 1);
      chk("rm_pc_ready", pc3_if.ready, 0);
      chk("rm_mreq_valid", mreq3_if.valid, 0);
      chk("rm_fetched_valid", fet3_if.valid, 0);
      chk("rm_mresp_ready", mresp3_if.ready, 0);
      step();
      rst = 1'b0; mresp3_if.valid = 1'b0; pc3_if.data = 32'h0;
      #1;
      chk("rm_post_live", u_dut3.live, 0);
      chk("rm_post_kill", u_dut3.kill_cnt, 0);
      chk("rm_post_pc_ready", pc3_if.ready, 1);
      chk("rm_post_mreq_valid", mreq3_if.valid, 1);
      chk("rm_post_mreq_a", mreq3.a, 32'h0);
      step();
      pc3_if.valid = 1'b0; mresp3_if.valid = 1'b1; mresp3_if.data = 32'hE000_0000;
      #1;
      chk("rm_f_valid", fet3_if.valid, 1);
      chk("rm_f_pc", fpkt3.pc, 32'h0);
      chk("rm_f_raw", fpkt3.raw, 32'hE000_0000);
      step();
      mresp3_if.valid = 1'b0;
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
